// File: rtl/rvfi_env_monitor.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_env_monitor
// Description : Environment monitor for the sentinel formal harness. Tracks
//               Wishbone stall/ack latency, trap-nesting depth and retired
//               shift amounts, and raises per-cycle violation flags.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_env_monitor #(
    parameter int MAX_WAIT  = 4,
    parameter int MIN_LAT   = 1,
    parameter int MAX_NEST  = 2,
    parameter int SHIFT_EN  = 1,
    parameter int SHIFT_MAX = 2,
    parameter int CNT_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           bus__cyc,
    input  logic                           bus__stb,
    input  logic                           bus__ack,
    input  logic                           rvfi_valid,
    input  logic                           rvfi_trap,
    input  logic [31:0]                    rvfi_insn,
    input  logic [31:0]                    rvfi_rs2_rdata,
    output logic [CNT_W-1:0]               wait_cnt,
    output logic [$clog2(MAX_NEST+1):0]    nest_depth,
    output logic                           ack_permitted,
    output logic                           early_ack,
    output logic                           wait_violation,
    output logic                           nest_violation,
    output logic                           shift_violation,
    output logic                           env_ok,
    output logic                           violation_sticky
);

    localparam int                 NEST_W      = $clog2(MAX_NEST+1) + 1;
    localparam logic [CNT_W-1:0]   c_MIN_LAT   = CNT_W'(MIN_LAT);
    localparam logic [CNT_W-1:0]   c_MAX_WAIT  = CNT_W'(MAX_WAIT);
    localparam logic [NEST_W-1:0]  c_MAX_NEST  = NEST_W'(MAX_NEST);
    localparam logic [31:0]        c_SHIFT_MAX = 32'(SHIFT_MAX);
    localparam logic [31:0]        c_MRET      = 32'h3020_0073;

    logic [CNT_W-1:0]  r_wait_cnt;
    logic [NEST_W-1:0] r_nest_depth;
    logic              r_sticky;

    logic              w_req;
    logic              w_stall;
    logic              w_is_mret;
    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_shift_f3;
    logic              w_shift_violation;

    assign w_req      = bus__cyc & bus__stb;
    assign w_stall    = w_req & ~bus__ack;
    assign w_is_mret  = (rvfi_insn == c_MRET);
    assign w_opcode   = rvfi_insn[6:0];
    assign w_funct3   = rvfi_insn[14:12];
    assign w_shift_f3 = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    generate
        if (SHIFT_EN != 0) begin : g_shift_on
            logic w_imm_shift;
            logic w_reg_shift;
            // Immediate shamt is zero-extended so SHIFT_MAX above 31 never flags.
            assign w_imm_shift = (w_opcode == 7'b0010011) && w_shift_f3 &&
                                 ({27'd0, rvfi_insn[24:20]} >= c_SHIFT_MAX);
            assign w_reg_shift = (w_opcode == 7'b0110011) && w_shift_f3 &&
                                 (rvfi_rs2_rdata >= c_SHIFT_MAX);
            assign w_shift_violation = rvfi_valid & (w_imm_shift | w_reg_shift);
        end else begin : g_shift_off
            logic w_unused_shift;
            assign w_unused_shift    = ^{rvfi_rs2_rdata, w_opcode, w_shift_f3};
            assign w_shift_violation = 1'b0;
        end
    endgenerate

    assign wait_cnt         = r_wait_cnt;
    assign nest_depth       = r_nest_depth;
    assign violation_sticky = r_sticky;

    assign ack_permitted   = w_req & (r_wait_cnt >= c_MIN_LAT);
    assign early_ack       = bus__ack & w_req & (r_wait_cnt < c_MIN_LAT);
    assign wait_violation  = w_stall & (r_wait_cnt >= c_MAX_WAIT);
    assign nest_violation  = (r_nest_depth >= c_MAX_NEST);
    assign shift_violation = w_shift_violation;
    assign env_ok          = ~(early_ack | wait_violation | nest_violation | w_shift_violation);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt   <= '0;
            r_nest_depth <= '0;
            r_sticky     <= 1'b0;
        end else begin
            if (w_stall) begin
                if (r_wait_cnt != {CNT_W{1'b1}}) begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
            end else begin
                r_wait_cnt <= '0;
            end

            // A trapping MRET is a trap; only a clean MRET unwinds a level.
            if (rvfi_valid && rvfi_trap) begin
                if (r_nest_depth != {NEST_W{1'b1}}) begin
                    r_nest_depth <= r_nest_depth + NEST_W'(1);
                end
            end else if (rvfi_valid && w_is_mret && (r_nest_depth != '0)) begin
                r_nest_depth <= r_nest_depth - NEST_W'(1);
            end

            r_sticky <= r_sticky | ~env_ok;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvfi_env_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_env_monitor
// Description : Scoreboard testbench for rvfi_env_monitor with directed and
//               random retirements/bus traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_env_monitor;

    localparam int MAX_WAIT  = 4;
    localparam int MIN_LAT   = 1;
    localparam int MAX_NEST  = 2;
    localparam int SHIFT_MAX = 2;
    localparam int CNT_W     = 4;
    localparam int NEST_W    = $clog2(MAX_NEST+1) + 1;
    localparam int WAIT_SAT  = (1 << CNT_W) - 1;
    localparam int NEST_SAT  = (1 << NEST_W) - 1;
    localparam logic [31:0] MRET = 32'h3020_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst, cyc, stb, ack, valid, trap;
    logic [31:0]       insn, rs2;
    logic [CNT_W-1:0]  wait_cnt;
    logic [NEST_W-1:0] nest_depth;
    logic              ack_permitted, early_ack, wait_violation, nest_violation;
    logic              shift_violation, env_ok, violation_sticky;

    logic [CNT_W-1:0]  o_wait_cnt;
    logic [NEST_W-1:0] o_nest_depth;
    logic              o_ack_permitted, o_early_ack, o_wait_violation, o_nest_violation;
    logic              o_shift_violation, o_env_ok, o_violation_sticky;

    always #5 clk = ~clk;

    rvfi_env_monitor dut (
        .clk(clk), .rst(rst), .bus__cyc(cyc), .bus__stb(stb), .bus__ack(ack),
        .rvfi_valid(valid), .rvfi_trap(trap), .rvfi_insn(insn), .rvfi_rs2_rdata(rs2),
        .wait_cnt(wait_cnt), .nest_depth(nest_depth), .ack_permitted(ack_permitted),
        .early_ack(early_ack), .wait_violation(wait_violation),
        .nest_violation(nest_violation), .shift_violation(shift_violation),
        .env_ok(env_ok), .violation_sticky(violation_sticky)
    );

    rvfi_env_monitor #(.SHIFT_EN(0)) dut_noshift (
        .clk(clk), .rst(rst), .bus__cyc(cyc), .bus__stb(stb), .bus__ack(ack),
        .rvfi_valid(valid), .rvfi_trap(trap), .rvfi_insn(insn), .rvfi_rs2_rdata(rs2),
        .wait_cnt(o_wait_cnt), .nest_depth(o_nest_depth), .ack_permitted(o_ack_permitted),
        .early_ack(o_early_ack), .wait_violation(o_wait_violation),
        .nest_violation(o_nest_violation), .shift_violation(o_shift_violation),
        .env_ok(o_env_ok), .violation_sticky(o_violation_sticky)
    );

    typedef struct {
        int wait_cnt;
        int nest_depth;
        int ack_permitted;
        int early_ack;
        int wait_violation;
        int nest_violation;
        int shift_violation;
        int env_ok;
        int sticky;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: consecutive stalled cycles, trap depth, any-violation latch.
    int   m_stalls = 0;
    int   m_depth  = 0;
    int   m_sticky = 0;

    function automatic int shift_flag(input logic v, input logic [31:0] i, input logic [31:0] d);
        int op, f3, shamt;
        op    = int'(i & 32'h7f);
        f3    = int'((i >> 12) & 32'h7);
        shamt = int'((i >> 20) & 32'h1f);
        if (!v || !(f3 == 1 || f3 == 5)) return 0;
        if (op == 'h13) return (shamt >= SHIFT_MAX) ? 1 : 0;
        if (op == 'h33) return (longint'(d) >= longint'(SHIFT_MAX)) ? 1 : 0;
        return 0;
    endfunction

    task automatic step(input logic r, input logic c, input logic s, input logic a,
                        input logic v, input logic t, input logic [31:0] i,
                        input logic [31:0] d);
        exp_t e;
        int   req;
        rst = r; cyc = c; stb = s; ack = a; valid = v; trap = t; insn = i; rs2 = d;
        req = (c && s) ? 1 : 0;
        e.wait_cnt        = m_stalls;
        e.nest_depth      = m_depth;
        e.ack_permitted   = (req == 1 && m_stalls >= MIN_LAT) ? 1 : 0;
        e.early_ack       = (req == 1 && a && m_stalls < MIN_LAT) ? 1 : 0;
        e.wait_violation  = (req == 1 && !a && m_stalls >= MAX_WAIT) ? 1 : 0;
        e.nest_violation  = (m_depth >= MAX_NEST) ? 1 : 0;
        e.shift_violation = shift_flag(v, i, d);
        e.env_ok          = (e.early_ack + e.wait_violation + e.nest_violation +
                             e.shift_violation == 0) ? 1 : 0;
        e.sticky          = m_sticky;
        sb_q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_stalls = 0; m_depth = 0; m_sticky = 0;
        end else begin
            m_stalls = (req == 1 && !a) ? ((m_stalls < WAIT_SAT) ? m_stalls + 1 : WAIT_SAT) : 0;
            if (v && t)                             m_depth = (m_depth < NEST_SAT) ? m_depth + 1 : NEST_SAT;
            else if (v && i == MRET && m_depth > 0) m_depth = m_depth - 1;
            if (e.env_ok == 0) m_sticky = 1;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, NOP, 32'd0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wait_cnt",         int'(wait_cnt),         e.wait_cnt);
                chk("nest_depth",       int'(nest_depth),       e.nest_depth);
                chk("ack_permitted",    int'(ack_permitted),    e.ack_permitted);
                chk("early_ack",        int'(early_ack),        e.early_ack);
                chk("wait_violation",   int'(wait_violation),   e.wait_violation);
                chk("nest_violation",   int'(nest_violation),   e.nest_violation);
                chk("shift_violation",  int'(shift_violation),  e.shift_violation);
                chk("env_ok",           int'(env_ok),           e.env_ok);
                chk("violation_sticky", int'(violation_sticky), e.sticky);
                chk("noshift_shift",    int'(o_shift_violation), 0);
            end
        end
    end

    function automatic logic [31:0] rand_insn();
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
        f7 = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0100000;
        case ($urandom_range(0, 5))
            0: return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0010011};
            1: return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
            2: return MRET;
            3: return $urandom;
            4: return {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
            default: return {7'b0, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0110011};
        endcase
    endfunction

    initial begin : stimulus
        int budget;
        rst = 1; cyc = 0; stb = 0; ack = 0; valid = 0; trap = 0; insn = NOP; rs2 = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with idle inputs
        idle();
        // Long stall: wait_cnt 0..5, flag at 4, sticky after
        repeat (6) step(0, 1, 1, 0, 0, 0, NOP, 32'd0);
        idle(); idle();
        step(1, 0, 0, 0, 0, 0, NOP, 32'd0);
        // Same-cycle ack is early; ack after one wait is permitted
        step(0, 1, 1, 1, 0, 0, NOP, 32'd0);
        idle();
        step(0, 1, 1, 0, 0, 0, NOP, 32'd0);
        step(0, 1, 1, 1, 0, 0, NOP, 32'd0);
        step(0, 1, 1, 0, 0, 0, NOP, 32'd0);
        step(0, 0, 0, 1, 0, 0, NOP, 32'd0);
        idle();
        // Trap nesting and MRET underflow protection
        step(0, 0, 0, 0, 1, 1, NOP, 32'd0);
        step(0, 0, 0, 0, 1, 1, NOP, 32'd0);
        step(0, 0, 0, 0, 1, 0, MRET, 32'd0);
        step(0, 0, 0, 0, 1, 0, MRET, 32'd0);
        step(0, 0, 0, 0, 1, 0, MRET, 32'd0);
        idle();
        // Shift checks: SLLI shamt 2/1, invalid retirement, SRL via rs2
        step(0, 0, 0, 0, 1, 0, 32'h0020_9093, 32'd0);
        step(0, 0, 0, 0, 1, 0, 32'h0010_9093, 32'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0020_9093, 32'd0);
        step(0, 0, 0, 0, 1, 0, 32'h0020_D0B3, 32'h0000_0001);
        step(0, 0, 0, 0, 1, 0, 32'h0020_D0B3, 32'h8000_0000);
        idle();
        // Reset mid-stall with a trap outstanding, then resume stalling
        step(1, 0, 0, 0, 0, 0, NOP, 32'd0);
        step(0, 1, 1, 0, 1, 1, NOP, 32'd0);
        step(0, 1, 1, 0, 0, 0, NOP, 32'd0);
        step(0, 1, 1, 0, 0, 0, NOP, 32'd0);
        step(0, 1, 1, 0, 0, 0, NOP, 32'd0);
        step(1, 1, 1, 0, 0, 0, NOP, 32'd0);
        step(0, 1, 1, 0, 0, 0, NOP, 32'd0);
        step(0, 1, 1, 0, 0, 0, NOP, 32'd0);
        step(0, 1, 1, 1, 0, 0, NOP, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic       r, c, s, a, v, t;
            logic [31:0] d;
            r = ($urandom_range(0, 63) == 0);
            c = ($urandom_range(0, 7) != 0);
            s = ($urandom_range(0, 5) != 0);
            a = ($urandom_range(0, 9) < 3);
            v = ($urandom_range(0, 1) == 1);
            t = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            step(r, c, s, a, v, t, rand_insn(), d);
        end
        idle();

        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
